// File: rtl/decode_cycle_if.sv
// ---------------------------------------------------------------------------
// decode_cycle_if
//
// Groups the fetch-stage inputs, the writeback port, the flush control and
// every ID/EX output of the decode stage into one bundle.
//
// There is no valid/ready handshake on this bus. The ID/EX register loads
// on every rising clock edge. FlushE replaces the loaded instruction with
// an all-zero bubble. The writeback port is a plain write strobe
// (RegWriteW) qualified by RdW != 0.
//
// Modports:
//   master : the pipeline around the decode stage (fetch, writeback,
//            hazard unit and execute stage); drives the inputs and observes
//            the outputs.
//   slave  : the decode stage itself.
//
// Signals:
//   InstrD, PCD, PCPlus4D   fetch-stage outputs (16 bit each)
//   RegWriteW, RdW, ResultW register-file write port
//   FlushE                  load a bubble into ID/EX
//   Rs1D, Rs2D              combinational source indices for hazard unit
//   *E                      registered ID/EX outputs to the execute stage
// ---------------------------------------------------------------------------
interface decode_cycle_if;
  logic [15:0] InstrD;
  logic [15:0] PCD;
  logic [15:0] PCPlus4D;
  logic        RegWriteW;
  logic [2:0]  RdW;
  logic [15:0] ResultW;
  logic        FlushE;

  logic [2:0]  Rs1D;
  logic [2:0]  Rs2D;

  logic        RegWriteE;
  logic        MemWriteE;
  logic        ResultSrcE;
  logic        BranchE;
  logic        JumpE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [15:0] RD1E;
  logic [15:0] RD2E;
  logic [15:0] ImmExtE;
  logic [15:0] PCE;
  logic [15:0] PCPlus4E;
  logic [2:0]  RdE;
  logic [2:0]  Rs1E;
  logic [2:0]  Rs2E;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  Rs1D, Rs2D,
    input  RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE,
    input  ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output Rs1D, Rs2D,
    output RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE,
    output ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
  );
endinterface

// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle
//
// Decode stage of the 16-bit five-stage pipeline. It splits InstrD into its
// fields, decodes the opcode into control signals and sign-extends the
// immediate. It reads the 8x16 register file and registers everything into
// the ID/EX pipeline register.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset; clears ID/EX and all registers
//   bus  : decode_cycle_if.slave, which carries the fetch inputs, the
//          writeback port, FlushE, Rs1D/Rs2D and all *E outputs
//
// Instruction fields: op[15:12] rd[11:9] rs1[8:6] rs2[5:3] funct[2:0]
//
// Configuration macro: DECODE_WB_BYPASS_EN
//   defined   - write-first register file. A same-cycle writeback to a
//               register being read is forwarded into RD1/RD2.
//   undefined - a same-cycle read returns the old register contents.
// ---------------------------------------------------------------------------
module decode_cycle (
  input  logic          clk,
  input  logic          rst,
  decode_cycle_if.slave bus
);

  localparam logic [3:0] OP_ALUR = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_JAL  = 4'h6;

  // Field extraction
  logic [3:0] op;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic [2:0] funct;

  assign op    = bus.InstrD[15:12];
  assign rd    = bus.InstrD[11:9];
  assign rs1   = bus.InstrD[8:6];
  assign rs2   = bus.InstrD[5:3];
  assign funct = bus.InstrD[2:0];

  // The hazard unit qualifies these by opcode, so they are exported raw.
  assign bus.Rs1D = rs1;
  assign bus.Rs2D = rs2;

  // Immediate formats
  logic [15:0] imm_i;
  logic [15:0] imm_sb;
  logic [15:0] imm_j;

  assign imm_i  = {{10{bus.InstrD[5]}}, bus.InstrD[5:0]};
  assign imm_sb = {{10{bus.InstrD[11]}}, bus.InstrD[11:9], bus.InstrD[2:0]};
  assign imm_j  = {{7{bus.InstrD[8]}}, bus.InstrD[8:0]};

  // Register file. Entry 0 is never written and stays zero, so r0 reads 0.
  logic [15:0] rf_q [8];
  logic        wb_en;

  assign wb_en = bus.RegWriteW && (bus.RdW != 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 16'h0000;
      end
    end else if (wb_en) begin
      rf_q[bus.RdW] <= bus.ResultW;
    end
  end

  logic [15:0] rd1;
  logic [15:0] rd2;

  always_comb begin
    rd1 = rf_q[rs1];
    rd2 = rf_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
    // Write-first: the value being written this edge wins over the array.
    if (wb_en && (bus.RdW == rs1)) rd1 = bus.ResultW;
    if (wb_en && (bus.RdW == rs2)) rd2 = bus.ResultW;
`endif
  end

  // Control decode. Opcodes 0x0 and 0x7..0xF fall to the all-zero default.
  logic        reg_write_d;
  logic        mem_write_d;
  logic        result_src_d;
  logic        branch_d;
  logic        jump_d;
  logic        alu_src_d;
  logic [2:0]  alu_ctl_d;
  logic [15:0] imm_d;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    alu_src_d    = 1'b0;
    alu_ctl_d    = 3'b000;
    imm_d        = 16'h0000;
    case (op)
      OP_ALUR: begin
        reg_write_d = 1'b1;
        alu_ctl_d   = funct;
      end
      OP_ADDI: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = imm_i;
      end
      OP_LW: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 1'b1;
        imm_d        = imm_i;
      end
      OP_SW: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = imm_sb;
      end
      OP_BEQ: begin
        branch_d  = 1'b1;
        alu_ctl_d = 3'b001;
        imm_d     = imm_sb;
      end
      OP_JAL: begin
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
        imm_d       = imm_j;
      end
      default: begin
      end
    endcase
  end

  // ID/EX pipeline register
  logic        reg_write_q;
  logic        mem_write_q;
  logic        result_src_q;
  logic        branch_q;
  logic        jump_q;
  logic        alu_src_q;
  logic [2:0]  alu_ctl_q;
  logic [15:0] rd1_q;
  logic [15:0] rd2_q;
  logic [15:0] imm_q;
  logic [15:0] pc_q;
  logic [15:0] pc_plus4_q;
  logic [2:0]  rd_q;
  logic [2:0]  rs1_q;
  logic [2:0]  rs2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || bus.FlushE) begin
      // Reset and flush both leave an all-zero NOP in execute. Reset is
      // asynchronous through the sensitivity list; flush acts on the edge.
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_ctl_q    <= 3'b000;
      rd1_q        <= 16'h0000;
      rd2_q        <= 16'h0000;
      imm_q        <= 16'h0000;
      pc_q         <= 16'h0000;
      pc_plus4_q   <= 16'h0000;
      rd_q         <= 3'd0;
      rs1_q        <= 3'd0;
      rs2_q        <= 3'd0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      alu_src_q    <= alu_src_d;
      alu_ctl_q    <= alu_ctl_d;
      rd1_q        <= rd1;
      rd2_q        <= rd2;
      imm_q        <= imm_d;
      pc_q         <= bus.PCD;
      pc_plus4_q   <= bus.PCPlus4D;
      rd_q         <= rd;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
    end
  end

  assign bus.RegWriteE   = reg_write_q;
  assign bus.MemWriteE   = mem_write_q;
  assign bus.ResultSrcE  = result_src_q;
  assign bus.BranchE     = branch_q;
  assign bus.JumpE       = jump_q;
  assign bus.ALUSrcE     = alu_src_q;
  assign bus.ALUControlE = alu_ctl_q;
  assign bus.RD1E        = rd1_q;
  assign bus.RD2E        = rd2_q;
  assign bus.ImmExtE     = imm_q;
  assign bus.PCE         = pc_q;
  assign bus.PCPlus4E    = pc_plus4_q;
  assign bus.RdE         = rd_q;
  assign bus.Rs1E        = rs1_q;
  assign bus.Rs2E        = rs2_q;

endmodule

// File: tb/tb_decode_cycle.sv
// ---------------------------------------------------------------------------
// tb_decode_cycle
//
// Bench for decode_cycle. Inputs change on the falling edge and outputs are
// sampled 1 ns after the rising edge. A vector table holds the directed
// cases with hand-computed expectations. A randomized phase is checked
// against an instruction-level model with its own register array. The run
// ends with an asynchronous mid-run reset sequence.
// ---------------------------------------------------------------------------
module tb_decode_cycle;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        result_src;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic [2:0]  alu_ctl;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [15:0] pcp4;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
  } eout_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pcp4;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        flush;
    eout_t       exp;
  } vec_t;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_cycle_if dif ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference register file, updated after each rising edge.
  logic [15:0] model_rf [8];

  vec_t vecs [11];

  // Helpers
  function automatic eout_t mk_e(input logic [5:0] ctl, input logic [2:0] alu,
                                 input logic [15:0] rd1, input logic [15:0] rd2,
                                 input logic [15:0] imm, input logic [15:0] pc,
                                 input logic [15:0] pcp4, input int rd,
                                 input int rs1, input int rs2);
    eout_t e;
    {e.reg_write, e.mem_write, e.result_src, e.branch, e.jump, e.alu_src} = ctl;
    e.alu_ctl = alu;
    e.rd1     = rd1;
    e.rd2     = rd2;
    e.imm     = imm;
    e.pc      = pc;
    e.pcp4    = pcp4;
    e.rd      = 3'(rd);
    e.rs1     = 3'(rs1);
    e.rs2     = 3'(rs2);
    return e;
  endfunction

  function automatic eout_t get_e();
    eout_t e;
    e.reg_write  = dif.RegWriteE;
    e.mem_write  = dif.MemWriteE;
    e.result_src = dif.ResultSrcE;
    e.branch     = dif.BranchE;
    e.jump       = dif.JumpE;
    e.alu_src    = dif.ALUSrcE;
    e.alu_ctl    = dif.ALUControlE;
    e.rd1        = dif.RD1E;
    e.rd2        = dif.RD2E;
    e.imm        = dif.ImmExtE;
    e.pc         = dif.PCE;
    e.pcp4       = dif.PCPlus4E;
    e.rd         = dif.RdE;
    e.rs1        = dif.Rs1E;
    e.rs2        = dif.Rs2E;
    return e;
  endfunction

  // Two's-complement value of the low 'bits' bits of v, as plain arithmetic.
  function automatic logic [15:0] sext(input int v, input int bits);
    int r;
    r = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    return 16'(r);
  endfunction

  // Register read as seen by decode this cycle, given the pending write.
  function automatic logic [15:0] model_read(input int idx, input logic wb_en,
                                             input int wb_rd, input logic [15:0] wb_data);
    if (idx == 0) return 16'h0000;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_rd == idx) return wb_data;
`endif
    return model_rf[idx];
  endfunction

  // Instruction-level decode model. Fields are taken by shifting and
  // masking, and immediates by arithmetic sign extension.
  function automatic eout_t model_decode(input logic [15:0] instr, input logic [15:0] pc,
                                         input logic [15:0] pcp4, input logic wb_en,
                                         input int wb_rd, input logic [15:0] wb_data);
    int op, rd, rs1, rs2, fn, v;
    eout_t e;
    v   = int'(instr);
    op  = v / 4096;
    rd  = (v >> 9) % 8;
    rs1 = (v >> 6) % 8;
    rs2 = (v >> 3) % 8;
    fn  = v % 8;
    e = mk_e(6'b000000, 3'd0, model_read(rs1, wb_en, wb_rd, wb_data),
             model_read(rs2, wb_en, wb_rd, wb_data), 16'h0000, pc, pcp4, rd, rs1, rs2);
    case (op)
      1: begin e.reg_write = 1'b1; e.alu_ctl = 3'(fn); end
      2: begin e.reg_write = 1'b1; e.alu_src = 1'b1; e.imm = sext(v % 64, 6); end
      3: begin e.reg_write = 1'b1; e.alu_src = 1'b1; e.result_src = 1'b1;
               e.imm = sext(v % 64, 6); end
      4: begin e.mem_write = 1'b1; e.alu_src = 1'b1; e.imm = sext(rd * 8 + fn, 6); end
      5: begin e.branch = 1'b1; e.alu_ctl = 3'd1; e.imm = sext(rd * 8 + fn, 6); end
      6: begin e.reg_write = 1'b1; e.jump = 1'b1; e.imm = sext(v % 512, 9); end
      default: begin end
    endcase
    return e;
  endfunction

  // Driver tasks
  task automatic drive(input logic [15:0] instr, input logic [15:0] pc,
                       input logic [15:0] pcp4, input logic wb_en,
                       input logic [2:0] wb_rd, input logic [15:0] wb_data,
                       input logic flush);
    dif.InstrD    = instr;
    dif.PCD       = pc;
    dif.PCPlus4D  = pcp4;
    dif.RegWriteW = wb_en;
    dif.RdW       = wb_rd;
    dif.ResultW   = wb_data;
    dif.FlushE    = flush;
  endtask

  task automatic model_write(input logic wb_en, input logic [2:0] wb_rd,
                             input logic [15:0] wb_data);
    if (wb_en && wb_rd != 3'd0) model_rf[wb_rd] = wb_data;
  endtask

  task automatic check_e(input string name, input eout_t exp);
    eout_t act;
    act = get_e();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rs(input string name, input logic [15:0] instr);
    logic [5:0] exp;
    exp = 6'(((int'(instr) >> 6) % 8) * 8 + ((int'(instr) >> 3) % 8));
    n_checks++;
    if ({dif.Rs1D, dif.Rs2D} !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, {dif.Rs1D, dif.Rs2D}, exp);
    end
  endtask

  // One full cycle: drive at the falling edge, check after the rising edge.
  task automatic cycle_check(input string name, input logic [15:0] instr,
                             input logic [15:0] pc, input logic [15:0] pcp4,
                             input logic wb_en, input logic [2:0] wb_rd,
                             input logic [15:0] wb_data, input logic flush,
                             input eout_t exp);
    @(negedge clk);
    drive(instr, pc, pcp4, wb_en, wb_rd, wb_data, flush);
    #1;
    check_rs({name, "_rsd"}, instr);
    @(posedge clk);
    #1;
    check_e(name, exp);
    model_write(wb_en, wb_rd, wb_data);
  endtask

  eout_t zero_e;

  initial begin
    zero_e = '0;
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;

    // Directed vectors, in order, starting from a cleared register file.
    //                     ctl: rw mw rs br j as
    vecs[0]  = '{16'h0000, 16'h0000, 16'h0001, 1'b1, 3'd2, 16'h1234, 1'b0,
                 mk_e(6'b000000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0)};
    vecs[1]  = '{16'h2481, 16'h0002, 16'h0003, 1'b0, 3'd0, 16'h0000, 1'b0,
                 mk_e(6'b100001, 3'd0, 16'h1234, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 2, 2, 0)};
    vecs[2]  = '{16'h203F, 16'h0004, 16'h0005, 1'b0, 3'd0, 16'h0000, 1'b0,
                 mk_e(6'b100001, 3'd0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0004, 16'h0005, 0, 0, 7)};
    vecs[3]  = '{16'h5E97, 16'h0006, 16'h0007, 1'b0, 3'd0, 16'h0000, 1'b0,
                 mk_e(6'b000100, 3'd1, 16'h1234, 16'h1234, 16'hFFFF, 16'h0006, 16'h0007, 7, 2, 2)};
    vecs[4]  = '{16'h6300, 16'h0008, 16'h0009, 1'b0, 3'd0, 16'h0000, 1'b0,
                 mk_e(6'b100010, 3'd0, 16'h0000, 16'h0000, 16'hFF00, 16'h0008, 16'h0009, 1, 4, 0)};
    vecs[5]  = '{16'h3446, 16'h000A, 16'h000B, 1'b1, 3'd5, 16'hBEEF, 1'b1, zero_e};
    // ALU-R rd=0 rs1=r5 rs2=r2 funct=3, with r3 <= 0x5555 in the same cycle.
    vecs[6]  = '{16'h1153, 16'h000C, 16'h000D, 1'b1, 3'd3, 16'h5555, 1'b0,
                 mk_e(6'b100000, 3'd3, 16'hBEEF, 16'h1234, 16'h0000, 16'h000C, 16'h000D, 0, 5, 2)};
    // Same-cycle write of r3 while it is being read.
`ifdef DECODE_WB_BYPASS_EN
    vecs[7]  = '{16'h10C8, 16'h000E, 16'h000F, 1'b1, 3'd3, 16'hAAAA, 1'b0,
                 mk_e(6'b100000, 3'd0, 16'hAAAA, 16'h0000, 16'h0000, 16'h000E, 16'h000F, 0, 3, 1)};
`else
    vecs[7]  = '{16'h10C8, 16'h000E, 16'h000F, 1'b1, 3'd3, 16'hAAAA, 1'b0,
                 mk_e(6'b100000, 3'd0, 16'h5555, 16'h0000, 16'h0000, 16'h000E, 16'h000F, 0, 3, 1)};
`endif
    // Illegal opcode 0xF decodes as NOP, while r0 <= 0xFFFF is attempted.
    vecs[8]  = '{16'hF1FF, 16'h0010, 16'h0011, 1'b1, 3'd0, 16'hFFFF, 1'b0,
                 mk_e(6'b000000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0011, 0, 7, 7)};
    vecs[9]  = '{16'h1000, 16'h0012, 16'h0013, 1'b0, 3'd0, 16'h0000, 1'b0,
                 mk_e(6'b100000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0012, 16'h0013, 0, 0, 0)};
    vecs[10] = '{16'h10C0, 16'h0014, 16'h0015, 1'b0, 3'd0, 16'h0000, 1'b0,
                 mk_e(6'b100000, 3'd0, 16'hAAAA, 16'h0000, 16'h0000, 16'h0014, 16'h0015, 0, 3, 0)};

    // Reset held with an ALU-R instruction presented.
    drive(16'h1000, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_e("reset_hold", zero_e);

    @(negedge clk);
    drive(16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      cycle_check($sformatf("vec%0d", i), vecs[i].instr, vecs[i].pc, vecs[i].pcp4,
                  vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_data, vecs[i].flush,
                  vecs[i].exp);
    end

    // Randomized phase against the instruction-level model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] instr, pc, wb_data;
      logic        wb_en, flush;
      logic [2:0]  wb_rd;
      eout_t       exp;
      instr   = 16'($urandom);
      pc      = 16'($urandom);
      wb_en   = ($urandom_range(0, 2) != 0);
      wb_rd   = 3'($urandom_range(0, 7));
      wb_data = 16'($urandom);
      flush   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        // Steer reads onto the register being written to hit the RAW case.
        instr[8:6] = wb_rd;
      end
      exp = flush ? zero_e : model_decode(instr, pc, pc + 16'd1, wb_en, int'(wb_rd), wb_data);
      cycle_check("rand", instr, pc, pc + 16'd1, wb_en, wb_rd, wb_data, flush, exp);
    end

    // Asynchronous reset in the middle of a cycle
    cycle_check("pre_async", 16'h2FFF, 16'h0100, 16'h0101, 1'b1, 3'd7, 16'h7777, 1'b0,
                model_decode(16'h2FFF, 16'h0100, 16'h0101, 1'b1, 7, 16'h7777));
    @(negedge clk);
    drive(16'h1000, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_e("async_reset", zero_e);
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Every register reads zero after reset.
    for (int k = 1; k < 8; k++) begin
      logic [15:0] instr;
      instr = 16'h1000 | 16'(k << 6) | 16'(k << 3);
      cycle_check($sformatf("post_reset_r%0d", k), instr, 16'h0000, 16'h0001,
                  1'b0, 3'd0, 16'h0000, 1'b0,
                  mk_e(6'b100000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                       16'h0001, 0, k, k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
